// File: rtl/drive_speed_ramp_ctrl.sv
// Speed ramp sequencer: slews current_percent toward a clamped setpoint at a
// programmable rate, drives a 100-step PWM and forces the drive off on estop.
module drive_speed_ramp_ctrl #(
    parameter int          PWM_PRESCALE = 500,
    parameter logic [15:0] RAMP_RESET   = 16'd1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  target_percent,
    input  logic        enable,
    input  logic        estop,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        pwm_out,
    output logic [6:0]  current_percent,
    output logic        at_target
);

    localparam int             PS_W   = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PWM_PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RAMP  = 2'd1,
        S_HOLD  = 2'd2,
        S_ESTOP = 2'd3
    } state_t;

    function automatic logic [6:0] sat_percent(input logic [6:0] p);
        return (p > 7'd100) ? 7'd100 : p;
    endfunction

    state_t          state, state_nxt;
    logic [15:0]     ramp_interval;
    logic [15:0]     ramp_cnt, ramp_cnt_nxt;
    logic [6:0]      current, current_nxt;
    logic            soft_en;
    logic [6:0]      eff;
    logic            wr_en;
    logic            step_due;
    logic [PS_W-1:0] prescale_cnt;
    logic [6:0]      step_cnt;
    logic [6:0]      duty, duty_now;
    logic            unused_wdata;

    assign wr_en        = chipselect && !write_n;
    assign eff          = (enable && soft_en) ? sat_percent(target_percent) : 7'd0;
    assign unused_wdata = ^writedata[31:16];

    // Next-state / slew logic; estop overrides every state
    always_comb begin
        state_nxt    = state;
        current_nxt  = current;
        ramp_cnt_nxt = ramp_cnt;
        step_due     = (ramp_interval == 16'd0) || (ramp_cnt >= ramp_interval - 16'd1);
        if (estop) begin
            state_nxt    = S_ESTOP;
            current_nxt  = 7'd0;
            ramp_cnt_nxt = 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    current_nxt  = 7'd0;
                    ramp_cnt_nxt = 16'd0;
                    if (eff != 7'd0) state_nxt = S_RAMP;
                end
                S_RAMP: begin
                    ramp_cnt_nxt = ramp_cnt + 16'd1;
                    if (step_due) begin
                        ramp_cnt_nxt = 16'd0;
                        if (ramp_interval == 16'd0)
                            current_nxt = eff;
                        else if (current < eff)
                            current_nxt = current + 7'd1;
                        else if (current > eff)
                            current_nxt = current - 7'd1;
                    end
                    if (current_nxt == eff)
                        state_nxt = (eff == 7'd0) ? S_IDLE : S_HOLD;
                end
                S_HOLD: begin
                    ramp_cnt_nxt = 16'd0;
                    if (eff != current) state_nxt = S_RAMP;
                end
                default: begin
                    current_nxt  = 7'd0;
                    ramp_cnt_nxt = 16'd0;
                    state_nxt    = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            current       <= 7'd0;
            ramp_cnt      <= 16'd0;
            at_target     <= 1'b1;
            ramp_interval <= RAMP_RESET;
            soft_en       <= 1'b0;
        end else begin
            state     <= state_nxt;
            current   <= current_nxt;
            ramp_cnt  <= ramp_cnt_nxt;
            at_target <= (current_nxt == eff);
            if (wr_en && address == 2'd0)
                ramp_interval <= writedata[15:0];
            if (estop)
                soft_en <= 1'b0;
            else if (wr_en && address == 2'd2)
                soft_en <= writedata[0];
        end
    end

    // PWM: duty only changes at the period start so each period is glitch-free
    assign duty_now = (step_cnt == 7'd0 && prescale_cnt == '0) ? current : duty;

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale_cnt <= '0;
            step_cnt     <= 7'd0;
            duty         <= 7'd0;
            pwm_out      <= 1'b0;
        end else begin
            if (prescale_cnt == PS_MAX) begin
                prescale_cnt <= '0;
                step_cnt     <= (step_cnt == 7'd99) ? 7'd0 : step_cnt + 7'd1;
            end else begin
                prescale_cnt <= prescale_cnt + 1'b1;
            end
            if (estop || state == S_ESTOP) begin
                duty    <= 7'd0;
                pwm_out <= 1'b0;
            end else begin
                duty    <= duty_now;
                pwm_out <= (step_cnt < duty_now);
            end
        end
    end

    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0:    readdata[15:0] = ramp_interval;
            2'd1:    readdata[9:0]  = {state, at_target, current};
            2'd2:    readdata[0]    = soft_en;
            default: readdata       = 32'd0;
        endcase
    end

    assign current_percent = current;

endmodule
